div_unit: RTL and testbench

Multi-cycle 32-bit divider for the MIPS execute stage, serving DIV and DIVU. It is the producer of the divider-stall signal that the hazard unit consumes as `stall_divE`. While a divide occupies E, it holds fetch, decode and execute. It then presents the quotient and remainder for the HI/LO write path on the single cycle in which the instruction is released.

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) for the execute stage; raises stall_div while busy.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and finishes in one cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic               stall_div,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shift, trial;
  logic [WIDTH-1:0]   rem_step, quo_step, rem_fix, quo_fix;

  always_comb begin
    a_neg = signed_div & dividend[WIDTH-1];
    b_neg = signed_div & divisor[WIDTH-1];
    abs_a = a_neg ? -dividend : dividend;
    abs_b = b_neg ? -divisor : divisor;

    // One restoring step: shift in the next dividend bit, keep the difference if it fits.
    shift    = {rem_q, quo_q[WIDTH-1]};
    trial    = shift - {1'b0, dvsr_q};
    rem_step = trial[WIDTH] ? shift[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    // With a zero divisor the remainder ends as |dividend|, so its sign fix restores the raw value.
    rem_fix = rsign_q ? -rem_step : rem_step;
    quo_fix = dz_q ? {WIDTH{1'b1}} : (qsign_q ? -quo_step : quo_step);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !annul) begin
          dvsr_d  = abs_b;
          quo_d   = abs_a;
          rem_d   = '0;
          cnt_d   = '0;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          dz_d    = (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            state_d  = StDone;
            done_d   = 1'b1;
            result_d = {dividend, {WIDTH{1'b1}}};
          end else begin
            state_d = StBusy;
          end
`else
          state_d = StBusy;
`endif
        end
      end
      StBusy: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (annul) begin
      state_d  = StIdle;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign stall_div = start & ~annul & (state_q != StDone);
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results and completion cycles,
// a negedge monitor pops and compares whenever done is presented.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stall_div;
  logic        done;
  logic [63:0] result;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .annul      (annul),
    .stall_div  (stall_div),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  localparam int LatFull = 33;
`ifdef DIV_ZERO_FAST_EN
  localparam int LatDz = 1;
`else
  localparam int LatDz = 33;
`endif

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation, value and cycle.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one divide in the current cycle (called just after a posedge with the unit idle).
  task automatic op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] exp, input int lat);
    int n;
    bit ended;
    n = 0;
    ended = 1'b0;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    sb.push_back('{exp, cyc + lat});
    for (int i = 0; i < 100 && !ended; i++) begin
      @(negedge clk);
      if (stall_div) begin
        n++;
        @(posedge clk);
        #1;
        dividend = $urandom;
        divisor  = $urandom;
      end else begin
        ended = 1'b1;
      end
    end
    if (!ended) chk("stall_timeout", 64'(1), 64'(0));
    chk("stall_cycles", 64'(n), 64'(lat));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    dividend   = '0;
    divisor    = '0;
    annul      = 1'b0;
    #12;
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", result, 64'(0));
    chk("rst_stall_idle", 64'(stall_div), 64'(0));
    start = 1'b1;
    #1;
    chk("rst_stall_start", 64'(stall_div), 64'(1));
    annul = 1'b1;
    #1;
    chk("rst_stall_annul", 64'(stall_div), 64'(0));
    start = 1'b0;
    annul = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, LatFull);
    op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, LatFull);
    op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, LatFull);
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, LatFull);
    op(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, LatFull);
    op(1'b0, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, LatDz);
    op(1'b1, 32'hFFFF_FFFB, 32'h0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, LatDz);

    // Annul in cycle 10; the unit must be idle again in cycle 11, where the next divide starts.
    signed_div = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    start      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", 64'(stall_div), 64'(0));
    @(posedge clk);
    #1;
    annul = 1'b0;
    op(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, LatFull);

    // Back-to-back: second divide starts the cycle after the first completes.
    op(1'b0, 32'd50, 32'd5, {32'h0, 32'd10}, LatFull);
    op(1'b0, 32'd51, 32'd5, {32'h1, 32'd10}, LatFull);

    // Reset mid-BUSY clears outputs immediately.
    signed_div = 1'b0;
    dividend   = 32'd77;
    divisor    = 32'd4;
    start      = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_result", result, 64'(0));
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op(1'b0, 32'd77, 32'd4, {32'h1, 32'd19}, LatFull);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
